// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
//
// Shared definitions for the CPU data-memory write buffer:
//   - default geometry (queue depth, byte-address width, data width)
//   - encoding of the memory-port FSM states (IDLE / WRITE / READ / RESP)
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Memory-port FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;  // no memory access in progress
    localparam logic [1:0] ST_WRITE = 2'd1;  // retiring the queue head
    localparam logic [1:0] ST_READ  = 2'd2;  // load miss read in progress
    localparam logic [1:0] ST_RESP  = 2'd3;  // load data presented from rd_q

endpackage

// File: rtl/write_buffer_fifo.sv
// ---------------------------------------------------------------------------
// write_buffer_fifo
//
// Circular store queue for the data write buffer. Each entry holds a word
// address and a data word. Head/tail pointers wrap naturally; the count is
// one bit wider so that full and empty are distinguishable.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push          enqueue request (ignored while full)
//   push_addr     word address of the new entry
//   push_data     data word of the new entry
//   pop           dequeue request (ignored while empty)
//   count         number of valid entries (0..DEPTH)
//   full, empty   queue status
//   head          head pointer (oldest entry)
//   head_addr     word address of the oldest entry
//   head_data     data word of the oldest entry
//   entry_addr    all stored word addresses, indexed by slot
//   entry_data    all stored data words, indexed by slot
//   entry_valid   per-slot valid flag
// ---------------------------------------------------------------------------
module write_buffer_fifo
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1,
    localparam int WA_W  = ADDR_W - 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WA_W-1:0]              push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [CNT_W-1:0]             count,
    output logic                         full,
    output logic                         empty,
    output logic [PTR_W-1:0]             head,
    output logic [WA_W-1:0]              head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [DEPTH-1:0][WA_W-1:0]   entry_addr,
    output logic [DEPTH-1:0][DATA_W-1:0] entry_data,
    output logic [DEPTH-1:0]             entry_valid
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0][WA_W-1:0]   addr_mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem_q;

    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] offset;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every variable assigned in an always_comb block gets a default at
    // the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) begin
            tail_d = tail_q + 1'b1;
        end
        if (do_pop) begin
            head_d = head_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments for all sequential state, so every flop
    // samples the pre-edge value of every other flop regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; a slot is only ever
    // read when the pointers/count mark it valid, so its contents after reset
    // do not matter and the array can map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem_q[tail_q] <= push_addr;
            data_mem_q[tail_q] <= push_data;
        end
    end

    // A slot is valid when its distance from the head (mod DEPTH) is below
    // the current count; this includes the head entry while it is in flight.
    always_comb begin
        offset      = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - head_q;
            entry_valid[i] = ({1'b0, offset} < count_q);
        end
    end

    assign count      = count_q;
    assign head       = head_q;
    assign head_addr  = addr_mem_q[head_q];
    assign head_data  = data_mem_q[head_q];
    assign entry_addr = addr_mem_q;
    assign entry_data = data_mem_q;

endmodule

// File: rtl/data_write_buffer.sv
// ---------------------------------------------------------------------------
// data_write_buffer
//
// Posted-store write buffer between the CPU MEM stage and a slow handshaked
// data memory. Stores are queued and retired in order; the pipeline only
// stalls on a store when the queue is full. Load misses are read from memory
// ahead of queued stores and returned through rd_q.
//
// Build option:
//   WB_FORWARD_EN  defined   -> loads compare against every valid queue entry
//                               and are answered combinationally on a hit.
//                  undefined -> no compare; every load waits until the queue
//                               is drained and the port idle, then reads.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   MR         CPU load request
//   MW         CPU store request (wins if MR is also set)
//   Addr       CPU byte address, word index Addr[ADDR_W-1:2]
//   WD         CPU store data
//   RD         load data, valid when MR=1 and stall=0
//   stall      CPU must hold its request and freeze upstream stages
//   mem_req    memory request, held until mem_ack
//   mem_we     1 = write, 0 = read
//   mem_addr   memory word-aligned byte address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid with mem_ack
//   mem_ack    one-cycle completion pulse
// ---------------------------------------------------------------------------
module data_write_buffer
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MR,
    input  logic              MW,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    // FSM and registered memory-port state.
    logic [1:0]        state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rd_q,        rd_d;

    // Queue interface.
    logic                         fifo_pop;
    logic [CNT_W-1:0]             fifo_count;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [PTR_W-1:0]             fifo_head;
    logic [WA_W-1:0]              head_addr;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0][WA_W-1:0]   entry_addr;
    logic [DEPTH-1:0][DATA_W-1:0] entry_data;
    logic [DEPTH-1:0]             entry_valid;

    logic              is_load;
    logic              load_miss;
    logic [WA_W-1:0]   cpu_word;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              read_ok_idle;
    logic              read_ok_ack;
    logic              unused_addr_lsbs;

    // A simultaneous MR/MW is treated as a store only.
    assign is_load  = MR && !MW;
    assign cpu_word = Addr[ADDR_W-1:2];

    write_buffer_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (MW),
        .push_addr   (cpu_word),
        .push_data   (WD),
        .pop         (fifo_pop),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head        (fifo_head),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .entry_addr  (entry_addr),
        .entry_data  (entry_data),
        .entry_valid (entry_valid)
    );

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] slot;

    // Walk the queue from oldest to youngest; a later match overrides an
    // earlier one, so the youngest matching store supplies the data.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = fifo_head + PTR_W'(k);
            if (entry_valid[slot] && (entry_addr[slot] == cpu_word)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[slot];
            end
        end
    end

    // A miss proves no queued store aliases the load, so the read may
    // overtake the queue as soon as the port is free.
    assign read_ok_idle = 1'b1;
    assign read_ok_ack  = 1'b1;
`else
    logic unused_fwd;

    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
    assign unused_fwd = ^{fifo_head, entry_addr, entry_data, entry_valid};

    // Without the compare a load may alias anything queued, so it waits for
    // the queue to drain completely; on a write ack the popping head must be
    // the last entry.
    assign read_ok_idle = fifo_empty;
    assign read_ok_ack  = (fifo_count == CNT_W'(1));
`endif

    assign load_miss        = is_load && !fwd_hit;
    assign unused_addr_lsbs = ^Addr[1:0];

    // CPU-facing response. A store stalls only on a full queue (a head that
    // retires this cycle does not help until next cycle). A missing load
    // stalls until RESP presents the captured memory data.
    always_comb begin
        stall = 1'b0;
        RD    = '0;
        if (MW) begin
            stall = fifo_full;
        end else if (is_load) begin
            if (fwd_hit) begin
                RD = fwd_data;
            end else begin
                RD    = rd_q;
                stall = (state_q != ST_RESP);
            end
        end
    end

    // Memory-port FSM. Request, address and data are registered and held
    // until ack; a new request can only be launched on the edge that ends
    // the ack cycle, so requests never overlap the ack.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_d        = rd_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A pending load miss wins over starting the next drain write.
                if (load_miss && read_ok_idle) begin
                    state_d    = ST_READ;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {cpu_word, 2'b00};
                end else if (!fifo_empty) begin
                    state_d     = ST_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {head_addr, 2'b00};
                    mem_wdata_d = head_data;
                end
            end

            ST_WRITE: begin
                if (mem_ack) begin
                    fifo_pop  = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                    // A load that waited behind this write issues right away.
                    if (load_miss && read_ok_ack) begin
                        state_d    = ST_READ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {cpu_word, 2'b00};
                    end
                end
            end

            ST_READ: begin
                if (mem_ack) begin
                    rd_d      = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_q        <= rd_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/data_write_buffer.md
# data_write_buffer

Posted-store write buffer between the CPU MEM stage (DataMemory port: MR/MW/Addr/WD/RD) and a slow, handshaked main data memory. Stores are queued and retired in order without stalling the pipeline unless the queue is full. Loads are answered from the queue on an address hit, otherwise read from memory ahead of queued stores. The block drives a stall back to the hazard logic (PCWrite/IF_ID_Write and pipeline-register hold).

## Interface
Parameters:
- DEPTH, 4, store-queue entries; power of two, ≥2
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- MR  in  1  CPU load request (EX_MEM_MemRead)
- MW  in  1  CPU store request (EX_MEM_MemWrite)
- Addr  in  ADDR_W  CPU byte address; word index = Addr[ADDR_W-1:2]
- WD  in  DATA_W  CPU store data
- RD  out  DATA_W  load data, valid when MR=1 and stall=0
- stall  out  1  CPU must hold MR/MW/Addr/WD and freeze upstream stages
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory word address (low 2 bits zero)
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse

## Operation
- Queue: circular, head/tail pointers log2(DEPTH) bits wrapping naturally; count is log2(DEPTH)+1 bits. Entry = {word addr, data}. Full-word stores only.
- Store (MW=1, count<DEPTH): enqueue at tail on clock edge; stall=0. With count==DEPTH: stall=1, no enqueue. A head retiring in the same cycle does not clear that cycle's stall; the store enqueues next cycle.
- MR=1 and MW=1 together is illegal; the block treats it as a store only.
- Load hit (WB_FORWARD_EN): compare against all valid entries, including the in-flight head. RD = youngest matching entry, combinational; stall=0; no memory access.
- Load miss: stall=1. Wait for any in-flight write's ack, then issue read (mem_we=0). On ack, capture mem_rdata in rd_q. Next cycle stall=0 and RD=rd_q.
- Load takes priority over starting the next drain write. This is safe because a miss means no queued entry aliases the address.
- FSM states:
  - IDLE: no access. Leave for WRITE when count>0 and no pending load miss; for READ on a load miss.
  - WRITE: mem_req=1, mem_we=1, addr/data from head. On ack, pop head, go to IDLE.
  - READ: mem_req=1, mem_we=0, mem_addr={Addr[ADDR_W-1:2],2'b00}. On ack, go to RESP.
  - RESP: stall=0, RD=rd_q; go to IDLE.
- mem_req and its address/data are registered and held stable until ack. The earliest next request is the cycle after ack, so requests are never back-to-back in the ack cycle.
- Reset values: state IDLE, count 0, head/tail 0, rd_q 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0. stall=0 and RD=0 when MR=MW=0.
- Reset mid-operation: queued stores are discarded and any in-flight request is abandoned; a late mem_ack after reset is ignored (state IDLE).

## Timing
- Store enqueue: 0-cycle stall when not full. Retire latency is ≥1 cycle + memory latency per entry.
- Load hit: same-cycle RD.
- Load miss from IDLE: load seen at T (stall high), mem_req rises at T+1. With ack at cycle A, stall stays high through A, drops at A+1, and RD is valid at A+1.
- Load miss while a write is in flight: the read issues the cycle after that write's ack.

## Configuration
- WB_FORWARD_EN defined: load-hit forwarding as above; loads may bypass queued stores.
- Undefined: no address compare. Every load stalls until count==0 and the FSM is in IDLE, then reads memory. RD only ever comes from rd_q.

## Structure
- Shared package `cpu_mem_pkg` holds the FSM state encoding (IDLE/WRITE/READ/RESP) and the default DEPTH/ADDR_W/DATA_W constants.
- Sub-module `write_buffer_fifo` holds the circular storage, pointers and count, and exposes the entry array for the hit compare. The top holds the FSM, the forward mux and rd_q.

## Test plan
- Reset, then store 0x11 to 0x100 and store 0x22 to 0x104 with memory ack after 3 cycles. Expect no stall, and writes appear on the memory port in order (0x100/0x11, then 0x104/0x22).
- Five stores with DEPTH=4 and ack withheld. Expect the 5th store to see stall=1 until the first ack frees a slot; the 5th store enqueues the cycle after ack.
- Store 0xAA to 0x200, then store 0xBB to 0x200, then load 0x200 before drain (WB_FORWARD_EN). Expect RD=0xBB the same cycle, stall=0, and no memory read.
- Load 0x300 (miss) with 2 stores queued, memory returns 0xCAFE. Expect the read to issue before the queued writes, stall through the ack cycle, then RD=0xCAFE.
- Assert rst while in READ with 3 entries queued, then send a stray ack. Expect all outputs at reset values, count=0, and no new request.
- WB_FORWARD_EN undefined: store 0x5 to 0x40, then load 0x40. Expect stall until the write is acked, then the read issues and RD equals memory data 0x5.
